// File: rtl/kb_frame_ctrl.sv
// PS/2 keyboard frame receiver: synchronizes and de-glitches kb_clk, then
// shifts in start/8 data/odd parity/stop on each filtered falling edge.
module kb_frame_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_clk,
  input  logic       kb_data,
  input  logic       rd_ack,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic [FILT_LEN-1:0]    r_hist;
  logic                   r_filt, r_fall;
  state_t                 r_state, w_nxt_state;
  logic [2:0]             r_bit, w_nxt_bit;
  logic [7:0]             r_sh, w_nxt_sh;
  logic                   r_par, w_nxt_par;
  logic [TW-1:0]          r_tcnt, w_nxt_tcnt;
  logic [7:0]             r_sc, w_nxt_sc;
  logic                   r_cv, w_nxt_cv;
  logic                   r_pe, w_nxt_pe, r_fe, w_nxt_fe, r_ov, w_nxt_ov;
  logic                   w_kclk, w_kdat, w_all0, w_all1, w_good;

  assign w_kclk = r_clk_sync[SYNC_STAGES-1];
  assign w_kdat = r_dat_sync[SYNC_STAGES-1];
  assign w_all0 = (r_hist == '0);
  assign w_all1 = &r_hist;

  // Input conditioning; everything idles high like an idle PS/2 bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_hist     <= '1;
      r_filt     <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], kb_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], kb_data};
      r_hist     <= {r_hist[FILT_LEN-2:0], w_kclk};
      if (w_all0)      r_filt <= 1'b0;
      else if (w_all1) r_filt <= 1'b1;
      r_fall     <= r_filt & w_all0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_sc    <= '0;
      r_cv    <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_bit   <= w_nxt_bit;
      r_sh    <= w_nxt_sh;
      r_par   <= w_nxt_par;
      r_tcnt  <= w_nxt_tcnt;
      r_sc    <= w_nxt_sc;
      r_cv    <= w_nxt_cv;
      r_pe    <= w_nxt_pe;
      r_fe    <= w_nxt_fe;
      r_ov    <= w_nxt_ov;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bit   = r_bit;
    w_nxt_sh    = r_sh;
    w_nxt_par   = r_par;
    w_nxt_sc    = r_sc;
    w_nxt_cv    = r_cv;
    w_nxt_pe    = 1'b0;
    w_nxt_fe    = 1'b0;
    w_nxt_ov    = 1'b0;
    w_good      = 1'b0;
    if (r_state == IDLE || r_fall) w_nxt_tcnt = '0;
    else                           w_nxt_tcnt = r_tcnt + TW'(1);

    // Timeout wins over a coincident fall strobe.
    if (r_state != IDLE && r_tcnt == TMAX) begin
      w_nxt_state = IDLE;
      w_nxt_fe    = 1'b1;
      w_nxt_sh    = '0;
      w_nxt_bit   = '0;
      w_nxt_tcnt  = '0;
    end else if (r_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_kdat) begin
            w_nxt_state = DATA;
            w_nxt_bit   = '0;
            w_nxt_sh    = '0;
          end else begin
            w_nxt_fe = 1'b1;
          end
        end
        DATA: begin
          w_nxt_sh[r_bit] = w_kdat;
          if (r_bit == 3'd7) w_nxt_state = PARITY;
          else               w_nxt_bit   = r_bit + 3'd1;
        end
        PARITY: begin
          w_nxt_par   = w_kdat;
          w_nxt_state = STOP;
        end
        STOP: begin
          w_nxt_state = IDLE;
          if (!w_kdat)              w_nxt_fe = 1'b1;
          else if (^{r_sh, r_par})  w_good   = 1'b1;
          else                      w_nxt_pe = 1'b1;
        end
        default: w_nxt_state = IDLE;
      endcase
    end

    // A completing frame takes precedence over a same-cycle acknowledge.
    if (w_good) begin
      w_nxt_sc = r_sh;
      w_nxt_cv = 1'b1;
      w_nxt_ov = r_cv & ~rd_ack;
    end else if (rd_ack) begin
      w_nxt_cv = 1'b0;
    end
  end

  assign scan_code  = r_sc;
  assign code_valid = r_cv;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign overrun    = r_ov;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_kb_frame_ctrl.sv
// Directed bench for kb_frame_ctrl: frames are bit-banged on kb_clk/kb_data and
// every output event is matched against a queue of expected results.
module tb_kb_frame_ctrl;

  localparam int TOUT = 2000;

  logic       clk = 1'b0, reset = 1'b1, kb_clk = 1'b1, kb_data = 1'b1, rd_ack = 1'b0;
  logic [7:0] scan_code;
  logic       code_valid, parity_err, frame_err, overrun, busy;

  kb_frame_ctrl #(.SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .kb_clk(kb_clk), .kb_data(kb_data), .rd_ack(rd_ack),
    .scan_code(scan_code), .code_valid(code_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sc;
    logic cv, pe, fe, ov, bs;
    logic lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_stop_cyc = 0;
  logic [7:0] p_sc;
  logic       p_cv;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: any pulse or change on scan_code/code_valid is an event.
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] obs, req;
    if (reset) begin
      p_sc = scan_code;
      p_cv = code_valid;
    end else begin
      if (parity_err || frame_err || overrun || code_valid != p_cv || scan_code != p_sc) begin
        checks++;
        assert (q.size() != 0) else begin
          failures++;
          $display("FAIL unexpected_event observed sc=%h cv=%b pe=%b fe=%b ov=%b required none",
                   scan_code, code_valid, parity_err, frame_err, overrun);
          $error("unexpected output event");
        end
        if (q.size() != 0) begin
          e   = q.pop_front();
          obs = {scan_code, code_valid, parity_err, frame_err, overrun, busy};
          req = {e.sc, e.cv, e.pe, e.fe, e.ov, e.bs};
          checks++;
          assert (obs === req) else begin
            failures++;
            $display("FAIL event observed {sc,cv,pe,fe,ov,busy}=%h required %h", obs, req);
            $error("event mismatch");
          end
          if (e.lat) begin
            checks++;
            assert (cyc === last_stop_cyc) else begin
              failures++;
              $display("FAIL latency observed cycle %0d required %0d", cyc, last_stop_cyc);
              $error("latency mismatch");
            end
          end
        end
      end
      p_sc = scan_code;
      p_cv = code_valid;
    end
  end

  task automatic expect_ev(input logic [7:0] sc, input logic cv, pe, fe, ov, lat);
    exp_t e;
    e.sc = sc; e.cv = cv; e.pe = pe; e.fe = fe; e.ov = ov; e.bs = 1'b0; e.lat = lat;
    q.push_back(e);
  endtask

  // One PS/2 bit; rd_ack (if requested) lands in the fall-strobe cycle.
  task automatic send_bit(input logic b, input logic ack);
    @(posedge clk); #1 kb_data = b;
    repeat (20) @(posedge clk);
    #1 kb_clk = 1'b0;
    repeat (7) @(posedge clk);
    #1 rd_ack = ack;
    @(posedge clk);
    #1 rd_ack = 1'b0;
    last_stop_cyc = cyc;
    repeat (32) @(posedge clk);
    #1 kb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop,
                            input logic ack);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par_ok ? ~^d : ^d, 1'b0);
    send_bit(stop, ack);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 rd_ack = 1'b1;
    @(posedge clk); #1 rd_ack = 1'b0;
    last_stop_cyc = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $display("FAIL drain observed %0d pending required 0", q.size());
      $error("expected event never arrived");
    end
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    checks++;
    assert (scan_code === 8'h00) else begin
      failures++; $display("FAIL %s_sc observed %h required 00", tag, scan_code); $error("sc");
    end
    checks++;
    assert ({code_valid, parity_err, frame_err, overrun, busy} === 5'b0) else begin
      failures++;
      $display("FAIL %s_flags observed %b required 00000", tag,
               {code_valid, parity_err, frame_err, overrun, busy});
      $error("flags");
    end
  endtask

  logic [7:0] b1c;

  initial begin
    b1c = 8'h1C;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    check_zero("reset");

    expect_ev(8'h1C, 1, 0, 0, 0, 1); send_frame(8'h1C, 1, 1, 0); wait_drain(100);
    expect_ev(8'h1C, 0, 0, 0, 0, 1); pulse_ack();                wait_drain(100);
    expect_ev(8'hF0, 1, 0, 0, 0, 1); send_frame(8'hF0, 1, 1, 0); wait_drain(100);
    expect_ev(8'hF0, 1, 1, 0, 0, 1); send_frame(8'hF0, 0, 1, 0); wait_drain(100);
    expect_ev(8'hF0, 1, 0, 1, 0, 1); send_frame(8'h1C, 1, 0, 0); wait_drain(100);
    expect_ev(8'hF0, 0, 0, 0, 0, 1); pulse_ack();                wait_drain(100);

    // Start + 5 data bits, then the bus goes quiet.
    expect_ev(8'hF0, 0, 0, 1, 0, 0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(b1c[i], 1'b0);
    wait_drain(3 * TOUT);
    expect_ev(8'h1C, 1, 0, 0, 0, 1); send_frame(8'h1C, 1, 1, 0); wait_drain(100);

    expect_ev(8'h32, 1, 0, 0, 1, 1); send_frame(8'h32, 1, 1, 0); wait_drain(100);
    expect_ev(8'hF0, 1, 0, 0, 0, 1); send_frame(8'hF0, 1, 1, 1); wait_drain(100);
    expect_ev(8'hF0, 0, 0, 0, 0, 1); pulse_ack();                wait_drain(100);

    // Reset mid-frame after 4 data bits.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b1c[i], 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_zero("midreset");
    expect_ev(8'h1C, 1, 0, 0, 0, 1); send_frame(8'h1C, 1, 1, 0); wait_drain(100);

    repeat (20) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kb_frame_ctrl.md
KB_FRAME_CTRL -- requirements
Module: kb_frame_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop stages on kb_clk and kb_data before use.
REQ-002 Parameter FILT_LEN, default 4: consecutive equal synced kb_clk samples needed to update the filtered clock.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: clk cycles without a kb_clk falling edge before a frame in progress is aborted.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 kb_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-007 kb_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-008 rd_ack  input  1  consumer acknowledge; clears code_valid.
REQ-009 scan_code  output  8  last good data byte, LSB first on the wire.
REQ-010 code_valid  output  1  scan_code holds an unread byte.
REQ-011 parity_err  output  1  one-cycle pulse: frame rejected for bad parity.
REQ-012 frame_err  output  1  one-cycle pulse: frame rejected for bad start bit, bad stop bit or timeout.
REQ-013 overrun  output  1  one-cycle pulse: good frame arrived while code_valid was high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 kb_clk and kb_data shall each pass through SYNC_STAGES flip-flops.
REQ-016 The filtered clock shall change only after FILT_LEN consecutive equal synced samples.
REQ-017 A registered fall strobe shall be high for exactly one cycle per 1->0 filtered-clock transition.
REQ-018 Synced kb_data shall be sampled only in the fall-strobe cycle.
REQ-019 FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE with fall strobe: sample 0 -> DATA with bit_cnt=0; sample 1 -> stay IDLE and pulse frame_err.
REQ-021 DATA: each fall strobe shifts the sample into a shift register at bit position bit_cnt and increments bit_cnt. After the 8th sample (bit_cnt=7 on entry), go to PARITY.
REQ-022 PARITY: fall strobe captures the parity bit and goes to STOP. Parity passes only if data bits plus parity bit contain an odd number of 1s.
REQ-023 STOP, fall strobe with sample 1 and parity pass: load scan_code from the shift register and set code_valid. Go to IDLE.
REQ-024 STOP, fall strobe with sample 1 and parity fail: pulse parity_err, leave scan_code and code_valid unchanged, go to IDLE.
REQ-025 STOP, fall strobe with sample 0: pulse frame_err and go to IDLE. This rule takes priority over the parity check.
REQ-026 Latency: scan_code, code_valid and the error pulses shall update on the clk edge after the stop-bit fall strobe.
REQ-027 Timeout counter: clears on every fall strobe and in IDLE, and counts up in DATA, PARITY and STOP.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1: pulse frame_err, go to IDLE and discard partial data. A fall strobe in the same cycle is ignored.
REQ-029 Good frame while code_valid=1 and rd_ack=0: overwrite scan_code, keep code_valid=1, pulse overrun.
REQ-030 rd_ack=1 with no good frame completing in the same cycle: clear code_valid.
REQ-031 rd_ack=1 in the same cycle a good frame completes: code_valid=1 with the new byte, and no overrun pulse.
REQ-032 rd_ack while code_valid=0 shall have no effect.
REQ-033 bit_cnt shall be 3 bits wide and shall never wrap inside DATA.

Reset
REQ-034 On reset: state=IDLE, bit_cnt=0, shift register=0, timeout counter=0, scan_code=8'h00, all synchronizer and filter flops=1, all outputs=0.
REQ-035 Reset mid-frame shall abort the frame with no error pulse. The next frame shall be received normally.

Verification
REQ-036 Frame 0,00111000,0,1 (byte 0x1C) -> one cycle after the stop edge: scan_code=0x1C, code_valid=1, no error pulses. Then rd_ack -> code_valid=0 on the next cycle.
REQ-037 Byte 0xF0 with parity bit 1 -> scan_code=0xF0. Same byte with parity bit 0 -> parity_err pulses once, scan_code unchanged, code_valid unchanged.
REQ-038 0x1C frame with stop bit 0 -> frame_err pulse, busy=0, code_valid unchanged.
REQ-039 Start bit plus 5 data bits, then kb_clk held high for TIMEOUT_CYCLES -> frame_err pulse, busy=0. A following 0x1C frame is received correctly.
REQ-040 0x1C, then 0x32 with no rd_ack -> overrun pulse, scan_code=0x32, code_valid=1. Next, rd_ack coincident with a 0xF0 completion -> code_valid=1, scan_code=0xF0, no overrun.
REQ-041 Reset asserted after 4 data bits -> all outputs 0, no error pulse. A following 0x1C frame is received correctly.
